// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial link: packet/opcode types, frame
// geometry, error bit positions and the reference CRC4 routine.
package alu_pkg;

  typedef enum logic {
    DATA = 1'b0,
    CTL  = 1'b1
  } packet_type_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_BAD2 = 3'b010,
    OP_BAD3 = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_BAD6 = 3'b110,
    OP_BAD7 = 3'b111
  } operation_t;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam int PKT_BITS  = 11;
  localparam int DATA_PKTS = 8;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Bit-serial x^4+x+1 over {B, A, 1'b1, op}, B[31] first, seed 0.
  function automatic logic [3:0] calc_crc4(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  op);
    logic [67:0] msg;
    logic [3:0]  c;
    logic        fb;
    msg = {b, a, 1'b1, op};
    c   = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1) accumulator; clear has priority over en.
module alu_crc4_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic       d,
  output logic [3:0] crc
);

  logic [3:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[3] ^ d;
    if (clear) begin
      crc_d = 4'b0000;
    end else if (en) begin
      crc_d = {crc_q[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 4'b0000;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/alu_serial_rx.sv
// Serial receive front end: deframes 11-bit packets, assembles {B,A} and the
// opcode, checks count/CRC/opcode and issues one checked command per frame.
module alu_serial_rx
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic [2:0]  cmd_op,
  output logic [2:0]  cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    PAYLOAD,
    STOP,
    RESYNC
  } state_t;

  state_t       state_q, state_d;
  packet_type_t type_q, type_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [63:0]  ba_q, ba_d;
  logic [3:0]   data_cnt_q, data_cnt_d;
  logic         frame_err_q, frame_err_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic [31:0]  cmd_a_q, cmd_a_d;
  logic [31:0]  cmd_b_q, cmd_b_d;
  logic [2:0]   cmd_op_q, cmd_op_d;
  logic [2:0]   cmd_err_q, cmd_err_d;

  logic         crc_clear, crc_en, crc_din;
  logic [3:0]   crc;

  alu_crc4_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (crc_clear),
    .en    (crc_en),
    .d     (crc_din),
    .crc   (crc)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ba_d        = ba_q;
    data_cnt_d  = data_cnt_q;
    frame_err_d = frame_err_q;
    cmd_valid_d = 1'b0;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    cmd_op_d    = cmd_op_q;
    cmd_err_d   = cmd_err_q;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;
    crc_din     = sin;

    case (state_q)
      IDLE: begin
        if (!sin) state_d = TYPE;
      end
      TYPE: begin
        type_d    = packet_type_t'(sin);
        bit_cnt_d = 3'd0;
        state_d   = PAYLOAD;
      end
      PAYLOAD: begin
        shreg_d   = {shreg_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        // CTL slot 0 carries the constant 1 of the CRC message in place of payload bit 7.
        if (type_q == DATA) begin
          crc_en = 1'b1;
        end else if (bit_cnt_q <= 3'd3) begin
          crc_en = 1'b1;
          if (bit_cnt_q == 3'd0) crc_din = 1'b1;
        end
        if (bit_cnt_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (sin) begin
          state_d = IDLE;
          if (type_q == DATA) begin
            ba_d = {ba_q[55:0], shreg_q};
            if (data_cnt_q != 4'd9) data_cnt_d = data_cnt_q + 4'd1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_a_d     = ba_q[31:0];
            cmd_b_d     = ba_q[63:32];
            cmd_op_d    = shreg_q[6:4];
            cmd_err_d   = 3'b000;
            if (data_cnt_q != 4'(DATA_PKTS) || frame_err_q) begin
              cmd_err_d[ERR_DATA] = 1'b1;
            end else if (shreg_q[3:0] != crc) begin
              cmd_err_d[ERR_CRC] = 1'b1;
            end else if (!op_is_valid(shreg_q[6:4])) begin
              cmd_err_d[ERR_OP] = 1'b1;
            end
            data_cnt_d  = 4'd0;
            frame_err_d = 1'b0;
            crc_clear   = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = RESYNC;
        end
      end
      RESYNC: begin
        if (sin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= DATA;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      ba_q        <= 64'h0;
      data_cnt_q  <= 4'd0;
      frame_err_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_a_q     <= 32'h0;
      cmd_b_q     <= 32'h0;
      cmd_op_q    <= 3'b000;
      cmd_err_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ba_q        <= ba_d;
      data_cnt_q  <= data_cnt_d;
      frame_err_q <= frame_err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      cmd_op_q    <= cmd_op_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_a     = cmd_a_q;
  assign cmd_b     = cmd_b_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: table vectors, random frames against
// a polynomial-division CRC model, and hand-written framing/reset sequences.
module tb_alu_serial_rx;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        cmd_valid;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  alu_serial_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err;
    int          cyc;
  } rec_t;

  rec_t rec_q[$];

  // Every cycle with cmd_valid high becomes one record, so a stretched pulse shows up as extra commands.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
      rec_t r;
      r.a   = cmd_a;
      r.b   = cmd_b;
      r.op  = cmd_op;
      r.err = cmd_err;
      r.cyc = cyc;
      rec_q.push_back(r);
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  crc_xor;
    int          ndata;
    logic [2:0]  exp_err;
  } vec_t;

  function automatic vec_t mk_vec(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input logic [3:0] crc_xor,
                                  input int ndata, input logic [2:0] exp_err);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.crc_xor = crc_xor; v.ndata = ndata; v.exp_err = exp_err;
    return v;
  endfunction

  // CRC as remainder of M(x)*x^4 divided by x^4+x+1, by long division.
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  function automatic logic [2:0] model_err(input vec_t v, input logic framing);
    if (v.ndata != 8 || framing) return 3'b100;
    if (v.crc_xor != 4'b0000) return 3'b010;
    if (!(v.op == 3'b000 || v.op == 3'b001 || v.op == 3'b100 || v.op == 3'b101)) return 3'b001;
    return 3'b000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic typ, input logic [7:0] payload, input logic stop_bit);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_frame_bits(input vec_t v, input logic ctl_stop, output int ctl_cyc);
    logic [63:0] ba;
    logic [7:0]  byte_v;
    logic [3:0]  crc_tx;
    ba = {v.b, v.a};
    for (int k = 0; k < v.ndata; k++) begin
      byte_v = (k < 8) ? ba[63 - 8*k -: 8] : 8'hC3;
      send_packet(DATA, byte_v, 1'b1);
    end
    crc_tx  = ref_crc(v.a, v.b, v.op) ^ v.crc_xor;
    ctl_cyc = cyc;
    send_packet(CTL, {1'b0, v.op, crc_tx}, ctl_stop);
  endtask

  task automatic check_rec(input string tag, input rec_t r, input vec_t v, input int ctl_cyc);
    checkOutput({tag, "_err"}, 64'(r.err), 64'(v.exp_err));
    checkOutput({tag, "_op"}, 64'(r.op), 64'(v.op));
    checkOutput({tag, "_latency"}, 64'(r.cyc - ctl_cyc), 64'(PKT_BITS));
    if (!v.exp_err[2]) begin
      checkOutput({tag, "_a"}, 64'(r.a), 64'(v.a));
      checkOutput({tag, "_b"}, 64'(r.b), 64'(v.b));
    end
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    int ctl_cyc;
    rec_q.delete();
    send_frame_bits(v, 1'b1, ctl_cyc);
    send_bit(1'b1);
    send_bit(1'b1);
    checkOutput({tag, "_cmd_count"}, 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check_rec(tag, rec_q[0], v, ctl_cyc);
  endtask

  vec_t tbl[10];

  initial begin
    vec_t v, v2;
    int   c1, c2;
    logic [7:0] ctl_byte;

    tbl[0] = mk_vec(32'h00000003, 32'h00000005, 3'b100, 4'h0, 8, 3'b000);
    tbl[1] = mk_vec(32'hFFFFFFFF, 32'h12345678, 3'b001, 4'h1, 8, 3'b010);
    tbl[2] = mk_vec(32'h00000001, 32'h00000002, 3'b101, 4'h0, 8, 3'b000);
    tbl[3] = mk_vec(32'h00000000, 32'hDEADBEEF, 3'b000, 4'h0, 2, 3'b100);
    tbl[4] = mk_vec(32'hCAFEF00D, 32'h13579BDF, 3'b000, 4'h0, 9, 3'b100);
    tbl[5] = mk_vec(32'h89ABCDEF, 32'h01234567, 3'b010, 4'h0, 8, 3'b001);
    tbl[6] = mk_vec(32'h55AA55AA, 32'hAA55AA55, 3'b110, 4'h0, 8, 3'b001);
    tbl[7] = mk_vec(32'h00FF00FF, 32'hFF00FF00, 3'b111, 4'h2, 8, 3'b010);
    tbl[8] = mk_vec(32'h11111111, 32'h22222222, 3'b100, 4'h8, 5, 3'b100);
    tbl[9] = mk_vec(32'h80000001, 32'h7FFFFFFE, 3'b000, 4'h0, 8, 3'b000);

    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(cmd_valid), 64'd0);
    checkOutput("reset_a", 64'(cmd_a), 64'd0);
    checkOutput("reset_b", 64'(cmd_b), 64'd0);
    checkOutput("reset_op", 64'(cmd_op), 64'd0);
    checkOutput("reset_err", 64'(cmd_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);

    for (int i = 0; i < 10; i++) applyStimulus($sformatf("vec%0d", i), tbl[i]);

    // Framing error in the 3rd DATA packet poisons the following frame only.
    rec_q.delete();
    send_packet(DATA, 8'h11, 1'b1);
    send_packet(DATA, 8'h22, 1'b1);
    send_packet(DATA, 8'h33, 1'b0);
    repeat (3) send_bit(1'b1);
    applyStimulus("framing", mk_vec(32'h0BADF00D, 32'h600DCAFE, 3'b100, 4'h0, 8, 3'b100));
    applyStimulus("framing_clean", mk_vec(32'h0BADF00D, 32'h600DCAFE, 3'b100, 4'h0, 8, 3'b000));

    // CTL with bad stop issues nothing; the next CTL alone reports ERR_DATA.
    v = mk_vec(32'h31415926, 32'h27182818, 3'b101, 4'h0, 8, 3'b100);
    rec_q.delete();
    send_frame_bits(v, 1'b0, c1);
    repeat (3) send_bit(1'b1);
    checkOutput("ctl_badstop_no_cmd", 64'(rec_q.size()), 64'd0);
    ctl_byte = {1'b0, v.op, ref_crc(v.a, v.b, v.op)};
    c1 = cyc;
    send_packet(CTL, ctl_byte, 1'b1);
    repeat (2) send_bit(1'b1);
    checkOutput("ctl_retry_count", 64'(rec_q.size()), 64'd1);
    if (rec_q.size() > 0) check_rec("ctl_retry", rec_q[0], v, c1);
    applyStimulus("ctl_clean", mk_vec(32'h31415926, 32'h27182818, 3'b101, 4'h0, 8, 3'b000));

    // Back-to-back frames: second start bit lands in the first cmd_valid cycle.
    v  = mk_vec(32'h01020304, 32'h05060708, 3'b001, 4'h0, 8, 3'b000);
    v2 = mk_vec(32'hA0B0C0D0, 32'hE0F01020, 3'b000, 4'h0, 8, 3'b000);
    rec_q.delete();
    send_frame_bits(v, 1'b1, c1);
    send_frame_bits(v2, 1'b1, c2);
    repeat (2) send_bit(1'b1);
    checkOutput("b2b_count", 64'(rec_q.size()), 64'd2);
    if (rec_q.size() > 1) begin
      check_rec("b2b_first", rec_q[0], v, c1);
      check_rec("b2b_second", rec_q[1], v2, c2);
    end

    // Reset in the middle of the 5th DATA packet.
    rec_q.delete();
    for (int k = 0; k < 4; k++) send_packet(DATA, 8'hE7, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_valid", 64'(cmd_valid), 64'd0);
    checkOutput("midreset_a", 64'(cmd_a), 64'd0);
    checkOutput("midreset_b", 64'(cmd_b), 64'd0);
    checkOutput("midreset_op", 64'(cmd_op), 64'd0);
    checkOutput("midreset_err", 64'(cmd_err), 64'd0);
    sin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sin   = 1'b1;
    rst_n = 1'b1;
    repeat (2) send_bit(1'b1);
    applyStimulus("after_reset", mk_vec(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b100, 4'h0, 8, 3'b000));

    // Random frames checked against the behavioural model.
    for (int i = 0; i < 24; i++) begin
      v.a       = $urandom;
      v.b       = $urandom;
      v.op      = 3'($urandom_range(0, 7));
      v.crc_xor = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.ndata   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 8;
      v.exp_err = model_err(v, 1'b0);
      applyStimulus($sformatf("rnd%0d", i), v);
      repeat ($urandom_range(0, 3)) send_bit(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
